// File: rtl/msg_pkg.sv
// Shared constants, FSM encoding and helpers for the message loader.
// Pure declarations; no logic, no latency.
// No handshaking; imported by every file in this block.
package msg_pkg;

    localparam int MSG_LEN = 16;
    localparam int CHAR_W  = 4;
    localparam int PTR_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Character increment that wraps F back to 0.
    function automatic char_t char_inc(input char_t c);
        return c + char_t'(1);
    endfunction

    // Identity pattern entry for a buffer slot.
    function automatic char_t ident_char(input int idx);
        return char_t'(idx);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter, stable level, press pulse.
// Press pulse appears DEBOUNCE_CYCLES+3 cycles after the first edge that samples a held high.
// No backpressure; the pulse is a single cycle and is not held for the consumer.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_out,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the raw, asynchronous button input.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreements; any agreement restarts the count, reaching the limit flips the stable level.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 != stable) begin
            if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered rising-edge detect on the stable level; releases give no pulse.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

    assign level = stable;

endmodule

// File: rtl/message_loader.sv
// Two-button message editor: edit buffer written by buttons, display buffer copied on commit.
// Buffer reads are combinational; a commit takes one cycle after the final cursor advance.
// No backpressure; presses landing in COMMIT are dropped.
module message_loader
    import msg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk_out,
    input  logic              reset,
    input  logic              btn_inc,
    input  logic              btn_next,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [CHAR_W-1:0] edit_val,
    output logic              editing,
    output logic              msg_update
);

    localparam ptr_t PTR_LAST = ptr_t'(MSG_LEN - 1);

    logic   inc_press;
    logic   next_press;
    logic   inc_level;
    logic   next_level;

    state_t state;
    state_t state_nxt;

    logic   do_inc;
    logic   do_adv;
    logic   do_copy;

    char_t  edit_buf [MSG_LEN];
    char_t  disp_buf [MSG_LEN];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_inc_db (
        .clk_out (clk_out),
        .reset   (reset),
        .raw     (btn_inc),
        .level   (inc_level),
        .press   (inc_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk_out (clk_out),
        .reset   (reset),
        .raw     (btn_next),
        .level   (next_level),
        .press   (next_press)
    );

    // FSM state register.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: any press wakes the editor, a next press at the last slot commits, commit lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (inc_press || next_press) begin
                    state_nxt = EDIT;
                end
            end
            EDIT: begin
                if (next_press && (wr_ptr == PTR_LAST)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs: status flags and the datapath strobes; the waking press is deliberately not a strobe.
    always_comb begin
        editing    = 1'b0;
        msg_update = 1'b0;
        do_inc     = 1'b0;
        do_adv     = 1'b0;
        do_copy    = 1'b0;
        case (state)
            EDIT: begin
                editing = 1'b1;
                do_inc  = inc_press;
                do_adv  = next_press;
            end
            COMMIT: begin
                msg_update = 1'b1;
                do_copy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Cursor: advances on next, wraps to 0 when leaving the last slot for COMMIT.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (do_adv) begin
            if (wr_ptr == PTR_LAST) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
        end
    end

    // Edit buffer: increment uses the pre-advance cursor, so a simultaneous inc+next hits the old slot.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                edit_buf[i] <= ident_char(i);
            end
        end else if (do_inc) begin
            edit_buf[wr_ptr] <= char_inc(edit_buf[wr_ptr]);
        end
    end

    // Display buffer: whole-message copy in the single COMMIT cycle, otherwise frozen.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                disp_buf[i] <= ident_char(i);
            end
        end else if (do_copy) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                disp_buf[i] <= edit_buf[i];
            end
        end
    end

    assign rd_data  = disp_buf[rd_addr];
    assign edit_val = edit_buf[wr_ptr];

endmodule

// File: tb/tb_message_loader.sv
// Directed bench for message_loader with DEBOUNCE_CYCLES=4.
// Expected values are hand-computed constants.
// Buttons are held long enough for press and release to debounce.
module tb_message_loader;

    localparam int DB = 4;

    logic       clk_out;
    logic       reset;
    logic       btn_inc;
    logic       btn_next;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] wr_ptr;
    logic [3:0] edit_val;
    logic       editing;
    logic       msg_update;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int upd_cnt  = 0;
    int inc_pulses = 0;

    message_loader #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_out    (clk_out),
        .reset      (reset),
        .btn_inc    (btn_inc),
        .btn_next   (btn_next),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_ptr     (wr_ptr),
        .edit_val   (edit_val),
        .editing    (editing),
        .msg_update (msg_update)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    // Count commit pulses and inc press pulses, one per high cycle.
    always @(negedge clk_out) begin
        if (msg_update) upd_cnt++;
        if (dut.u_inc_db.press) inc_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic i, input logic n);
        @(negedge clk_out);
        btn_inc  = i;
        btn_next = n;
        repeat (10) @(negedge clk_out);
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        repeat (10) @(negedge clk_out);
    endtask

    task automatic do_reset();
        @(negedge clk_out);
        reset = 1'b1;
        repeat (2) @(negedge clk_out);
        reset = 1'b0;
        @(negedge clk_out);
    endtask

    // Sweep the display buffer against an expected image.
    task automatic sweep(input string tag, input logic [63:0] img);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(img[a*4 +: 4]));
        end
    endtask

    logic [63:0] ident;
    logic [63:0] img;
    int          first_k;
    int          pulses_k;
    int          base_upd;
    int          base_inc;

    initial begin
        reset    = 1'b1;
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        rd_addr  = 4'd0;
        for (int a = 0; a < 16; a++) ident[a*4 +: 4] = 4'(a);

        // Reset state
        repeat (3) @(negedge clk_out);
        chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_msg_update", 32'(msg_update), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk_out);
        sweep("rst_disp", ident);
        chk("rst_upd_cnt", 32'(upd_cnt), 32'd0);

        // Glitches shorter than the debounce window give no pulse
        base_inc = inc_pulses;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk_out);
            btn_inc = 1'b1;
            repeat (2) @(negedge clk_out);
            btn_inc = 1'b0;
            repeat (12) @(negedge clk_out);
        end
        chk("glitch_pulses", 32'(inc_pulses - base_inc), 32'd0);
        chk("glitch_editing", 32'(editing), 32'd0);

        // Held press: pulse exactly DB+3 edges after the first sampling edge
        first_k  = 0;
        pulses_k = 0;
        @(negedge clk_out);
        btn_inc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_out);
            #1;
            if (dut.u_inc_db.press) begin
                pulses_k++;
                if (first_k == 0) first_k = k;
            end
        end
        @(negedge clk_out);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk_out);
        chk("press_latency", 32'(first_k - 1), 32'd7);
        chk("press_count_hold", 32'(pulses_k), 32'd1);
        chk("press_count_total", 32'(inc_pulses - base_inc), 32'd1);
        chk("hold_enters_edit", 32'(editing), 32'd1);

        // Edit slot 0 to 3, walk to the end, commit
        do_reset();
        base_upd = upd_cnt;
        press(1'b1, 1'b0);
        chk("wake_editing", 32'(editing), 32'd1);
        chk("wake_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("wake_edit_val", 32'(edit_val), 32'd0);
        repeat (3) press(1'b1, 1'b0);
        chk("inc3_edit_val", 32'(edit_val), 32'd3);
        repeat (15) press(1'b0, 1'b1);
        chk("walk_wr_ptr", 32'(wr_ptr), 32'd15);
        chk("walk_no_commit", 32'(upd_cnt - base_upd), 32'd0);
        sweep("precommit_disp", ident);
        press(1'b0, 1'b1);
        chk("commit_upd", 32'(upd_cnt - base_upd), 32'd1);
        chk("commit_editing", 32'(editing), 32'd0);
        chk("commit_wr_ptr", 32'(wr_ptr), 32'd0);
        img = ident;
        img[3:0] = 4'h3;
        sweep("commit1_disp", img);

        // Simultaneous inc+next at slot 2 holding F, then wrap at slot 15
        do_reset();
        base_upd = upd_cnt;
        press(1'b1, 1'b0);
        repeat (2) press(1'b0, 1'b1);
        repeat (13) press(1'b1, 1'b0);
        chk("slot2_is_f", 32'(edit_val), 32'hF);
        chk("slot2_wr_ptr", 32'(wr_ptr), 32'd2);
        press(1'b1, 1'b1);
        chk("both_wr_ptr", 32'(wr_ptr), 32'd3);
        chk("both_edit_val_slot3", 32'(edit_val), 32'd3);
        repeat (12) press(1'b0, 1'b1);
        chk("slot15_wr_ptr", 32'(wr_ptr), 32'd15);
        chk("slot15_val", 32'(edit_val), 32'hF);
        press(1'b1, 1'b1);
        chk("wrap_upd", 32'(upd_cnt - base_upd), 32'd1);
        chk("wrap_editing", 32'(editing), 32'd0);
        img = ident;
        img[2*4 +: 4]  = 4'h0;
        img[15*4 +: 4] = 4'h0;
        sweep("commit2_disp", img);

        // Reset mid-edit discards everything
        do_reset();
        base_upd = upd_cnt;
        press(1'b1, 1'b0);
        repeat (2) press(1'b1, 1'b0);
        repeat (9) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("mid_wr_ptr", 32'(wr_ptr), 32'd9);
        chk("mid_edit_val", 32'(edit_val), 32'hA);
        @(negedge clk_out);
        reset = 1'b1;
        #1;
        chk("async_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("async_editing", 32'(editing), 32'd0);
        chk("async_msg_update", 32'(msg_update), 32'd0);
        repeat (2) @(negedge clk_out);
        reset = 1'b0;
        repeat (2) @(negedge clk_out);
        chk("abort_upd", 32'(upd_cnt - base_upd), 32'd0);
        sweep("abort_disp", ident);
        press(1'b0, 1'b1);
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("abort_edit[%0d]", s), 32'(edit_val), 32'(s));
            if (s < 15) press(1'b0, 1'b1);
        end
        chk("abort_final_upd", 32'(upd_cnt - base_upd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
